// File: rtl/frame_serializer_tx_pkg.sv
// Shared types and constants for the serial frame transmitter.
// Optional Manchester line coding is enabled with the TX_MANCHESTER_EN macro.
package frame_serializer_tx_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPreamble = 3'd1,
    StSync     = 3'd2,
    StPayload  = 3'd3,
    StParity   = 3'd4,
    StGap      = 3'd5
  } state_e;

  localparam logic [7:0] DefaultSyncWord = 8'hB4;
  localparam logic       RstEnable       = 1'b0;
  localparam logic       LineIdle        = 1'b0;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/frame_serializer_tx_if.sv
// Byte handshake, abort and serial-line signals of the frame transmitter.
interface frame_serializer_tx_if;
  logic [7:0] data_i;
  logic       data_valid_i;
  logic       data_ready_o;
  logic       abort_i;
  logic       data_o;
  logic       busy_o;
  logic       frame_done_o;

  modport master (
    output data_i, data_valid_i, abort_i,
    input  data_ready_o, data_o, busy_o, frame_done_o
  );

  modport slave (
    input  data_i, data_valid_i, abort_i,
    output data_ready_o, data_o, busy_o, frame_done_o
  );
endinterface

// File: rtl/frame_serializer_tx_bit_timer.sv
// Clock-per-bit and bit-per-state counters; exposes next-cycle bit index so the line can be
// registered in step with the counters. TX_MANCHESTER_EN adds the half-bit phase output.
module frame_serializer_tx_bit_timer
  import frame_serializer_tx_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 16,
  parameter int unsigned BitW       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic [BitW-1:0] term_i,
  output logic            bit_tick_o,
  output logic            last_bit_o,
  output logic [2:0]      bit_idx_o
`ifdef TX_MANCHESTER_EN
  ,
  output logic            second_half_o
`endif
);

  localparam int unsigned CycW = $clog2(BIT_CYCLES);

  logic [CycW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;

  assign bit_tick_o = (cyc_cnt_q == CycW'(BIT_CYCLES - 1));
  assign last_bit_o = (bit_cnt_q == term_i - BitW'(1));

  // Clear wins over the tick, so bit_cnt never passes the terminal count.
  always_comb begin
    cyc_cnt_d = cyc_cnt_q + CycW'(1);
    bit_cnt_d = bit_cnt_q;
    if (clr_i) begin
      cyc_cnt_d = '0;
      bit_cnt_d = '0;
    end else if (bit_tick_o) begin
      cyc_cnt_d = '0;
      bit_cnt_d = bit_cnt_q + BitW'(1);
    end
  end

  assign bit_idx_o = bit_cnt_d[2:0];
`ifdef TX_MANCHESTER_EN
  assign second_half_o = (cyc_cnt_d >= CycW'(BIT_CYCLES / 2));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      cyc_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/frame_serializer_tx.sv
// Frame transmitter: preamble, sync word, payload MSB first, even parity, then a forced idle gap.
// Define TX_MANCHESTER_EN to Manchester-code every non-gap bit.
module frame_serializer_tx
  import frame_serializer_tx_pkg::*;
#(
  parameter int unsigned BIT_CYCLES    = 16,
  parameter int unsigned PREAMBLE_BITS = 8,
  parameter logic [7:0]  SYNC_WORD     = DefaultSyncWord,
  parameter int unsigned GAP_BITS      = 2
) (
  input logic                  clk,
  input logic                  rst,
  frame_serializer_tx_if.slave bus
);

  localparam int unsigned BitW = $clog2(max3(PREAMBLE_BITS, 8, GAP_BITS) + 1);

  state_e          state_q, state_d;
  logic [7:0]      byte_q, byte_d;
  logic            par_q, par_d;
  logic            data_q, data_d;
  logic [BitW-1:0] term;
  logic            clr, bit_tick, last_bit, end_bit, line;
  logic [2:0]      bit_idx;
`ifdef TX_MANCHESTER_EN
  logic            second_half;
`endif

  frame_serializer_tx_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES),
    .BitW      (BitW)
  ) u_bit_timer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (clr),
    .term_i       (term),
    .bit_tick_o   (bit_tick),
    .last_bit_o   (last_bit),
    .bit_idx_o    (bit_idx)
`ifdef TX_MANCHESTER_EN
    ,
    .second_half_o(second_half)
`endif
  );

  assign end_bit = bit_tick & last_bit;
  assign clr     = (state_d != state_q) || (state_q == StIdle);

  always_comb begin
    term = BitW'(1);
    unique case (state_q)
      StPreamble: term = BitW'(PREAMBLE_BITS);
      StSync:     term = BitW'(8);
      StPayload:  term = BitW'(8);
      StGap:      term = BitW'(GAP_BITS);
      default:    term = BitW'(1);
    endcase
  end

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    par_d   = par_q;
    unique case (state_q)
      StIdle: begin
        if (bus.data_valid_i) begin
          byte_d  = bus.data_i;
          par_d   = ^bus.data_i;
          state_d = StPreamble;
        end
      end
      StPreamble: if (bus.abort_i) state_d = StGap; else if (end_bit) state_d = StSync;
      StSync:     if (bus.abort_i) state_d = StGap; else if (end_bit) state_d = StPayload;
      StPayload:  if (bus.abort_i) state_d = StGap; else if (end_bit) state_d = StParity;
      StParity:   if (bus.abort_i || end_bit) state_d = StGap;
      StGap:      if (end_bit) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Line value is chosen from next-cycle state and bit index so data_o is registered
  // yet shows the first preamble bit right after the acceptance edge.
  always_comb begin
    line = LineIdle;
    unique case (state_d)
      StPreamble: line = ~bit_idx[0];
      StSync:     line = SYNC_WORD[~bit_idx];
      StPayload:  line = byte_q[~bit_idx];
      StParity:   line = par_q;
      default:    line = LineIdle;
    endcase
`ifdef TX_MANCHESTER_EN
    if ((state_d inside {StPreamble, StSync, StPayload, StParity}) && second_half) begin
      line = ~line;
    end
`endif
    data_d = line;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state_q <= StIdle;
      byte_q  <= '0;
      par_q   <= 1'b0;
      data_q  <= LineIdle;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      par_q   <= par_d;
      data_q  <= data_d;
    end
  end

  assign bus.data_o       = data_q;
  assign bus.busy_o       = (state_q != StIdle);
  assign bus.data_ready_o = (state_q == StIdle);
  assign bus.frame_done_o = (state_q == StParity) & end_bit & ~bus.abort_i;

endmodule

// File: tb/tb_frame_serializer_tx.sv
// Directed, table-driven bench for frame_serializer_tx; follows TX_MANCHESTER_EN for line coding.
module tb_frame_serializer_tx;

  localparam int         MaxCyc   = 440;
  localparam logic [7:0] SyncWord = 8'hB4;

  typedef struct {
    int   cyc;
    logic busy;
    logic ready;
    logic done;
  } tvec_t;

  logic  clk = 1'b0;
  logic  rst;
  int    n_checks = 0;
  int    n_pass   = 0;
  logic  rec_d[0:MaxCyc];
  logic  rec_b[0:MaxCyc];
  logic  rec_r[0:MaxCyc];
  logic  rec_f[0:MaxCyc];
  logic  fb[0:24];
  tvec_t tv[0:5];

  frame_serializer_tx_if bus ();

  frame_serializer_tx dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic sample(input int c);
    rec_d[c] = bus.data_o;
    rec_b[c] = bus.busy_o;
    rec_r[c] = bus.data_ready_o;
    rec_f[c] = bus.frame_done_o;
  endtask

  task automatic step_sample(input int c);
    @(posedge clk);
    #1;
    sample(c);
  endtask

  task automatic capture(input int upto);
    for (int c = 2; c <= upto; c++) step_sample(c);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.data_ready_o !== 1'b1 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ready_before_accept", bus.data_ready_o, 1);
  endtask

  // Leaves the bench sampled at cycle 1 of the new frame.
  task automatic accept(input logic [7:0] b, input logic ab);
    wait_ready();
    bus.data_i       = b;
    bus.data_valid_i = 1'b1;
    bus.abort_i      = ab;
    @(posedge clk);
    #1;
    bus.data_valid_i = 1'b0;
    bus.abort_i      = 1'b0;
    sample(1);
  endtask

  task automatic build(input logic [7:0] b);
    for (int k = 0; k < 8; k++) begin
      fb[k]      = (k % 2 == 0);
      fb[8 + k]  = SyncWord[7 - k];
      fb[16 + k] = b[7 - k];
    end
    fb[24] = ^b;
  endtask

  function automatic logic exp_line(input int c);
    int   ph;
    logic v;
    if (c < 1 || c > 400) return 1'b0;
    ph = (c - 1) % 16;
    v  = fb[(c - 1) / 16];
`ifdef TX_MANCHESTER_EN
    if (ph >= 8) v = ~v;
`endif
    return v;
  endfunction

  function automatic int done_count(input int from, input int upto);
    int n = 0;
    for (int c = from; c <= upto; c++) if (rec_f[c] === 1'b1) n++;
    return n;
  endfunction

  // Full-frame check: every bit at both ends and around the half-bit boundary, plus timing table.
  task automatic check_frame(input string name);
    int ph[4] = '{0, 7, 8, 15};
    for (int k = 0; k < 25; k++) begin
      for (int p = 0; p < 4; p++) begin
        check($sformatf("%s_bit%0d_ph%0d", name, k, ph[p]), rec_d[1 + 16 * k + ph[p]],
              exp_line(1 + 16 * k + ph[p]));
      end
    end
    check({name, "_gap401"}, rec_d[401], 0);
    check({name, "_gap432"}, rec_d[432], 0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s_busy_c%0d", name, tv[i].cyc), rec_b[tv[i].cyc], tv[i].busy);
      check($sformatf("%s_ready_c%0d", name, tv[i].cyc), rec_r[tv[i].cyc], tv[i].ready);
      check($sformatf("%s_done_c%0d", name, tv[i].cyc), rec_f[tv[i].cyc], tv[i].done);
    end
    check({name, "_done_count"}, done_count(1, 433), 1);
  endtask

  initial begin
    tv[0] = '{cyc: 1,   busy: 1'b1, ready: 1'b0, done: 1'b0};
    tv[1] = '{cyc: 399, busy: 1'b1, ready: 1'b0, done: 1'b0};
    tv[2] = '{cyc: 400, busy: 1'b1, ready: 1'b0, done: 1'b1};
    tv[3] = '{cyc: 401, busy: 1'b1, ready: 1'b0, done: 1'b0};
    tv[4] = '{cyc: 432, busy: 1'b1, ready: 1'b0, done: 1'b0};
    tv[5] = '{cyc: 433, busy: 1'b0, ready: 1'b1, done: 1'b0};

    bus.data_i       = 8'h00;
    bus.data_valid_i = 1'b0;
    bus.abort_i      = 1'b0;
    rst              = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_data", bus.data_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_ready", bus.data_ready_o, 1);
    check("rst_done", bus.frame_done_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic frame.
    build(8'hA5);
    accept(8'hA5, 1'b0);
    capture(MaxCyc);
    check_frame("a5");

    // Odd payload weight gives parity 1; abort alongside acceptance in IDLE is ignored.
    build(8'h07);
    accept(8'h07, 1'b1);
    capture(MaxCyc);
    check_frame("x07");
    check("x07_parity_first", rec_d[385], exp_line(385));
    check("x07_busy_c200", rec_b[200], 1);

    // Manchester-sensitive payload pattern.
    build(8'h80);
    accept(8'h80, 1'b0);
    capture(MaxCyc);
    check_frame("x80");

    // Back-to-back with valid held: second byte accepted on cycle 433 exactly.
    wait_ready();
    bus.data_i       = 8'h01;
    bus.data_valid_i = 1'b1;
    @(posedge clk);
    #1;
    sample(1);
    bus.data_i = 8'h02;
    for (int c = 2; c <= 434; c++) step_sample(c);
    bus.data_valid_i = 1'b0;
    build(8'h01);
    check("b2b_ready_c432", rec_r[432], 0);
    check("b2b_ready_c433", rec_r[433], 1);
    check("b2b_ready_c434", rec_r[434], 0);
    check("b2b_busy_c434", rec_b[434], 1);
    check("b2b_data_c434", rec_d[434], 1);
    check("b2b_first_done", done_count(1, 433), 1);
    for (int k = 16; k < 25; k++) begin
      check($sformatf("b2b_first_bit%0d", k), rec_d[1 + 16 * k + 3], exp_line(1 + 16 * k + 3));
    end
    sample(1);
    capture(MaxCyc);
    build(8'h02);
    check_frame("b2b_second");
    check("b2b_no_dup_busy", rec_b[440], 0);

    // Abort inside SYNC at cycle 150.
    build(8'hFF);
    accept(8'hFF, 1'b0);
    for (int c = 2; c <= 200; c++) begin
      step_sample(c);
      if (c == 150) bus.abort_i = 1'b1;
      if (c == 151) bus.abort_i = 1'b0;
    end
    check("abort_pre_data_c130", rec_d[130], exp_line(130));
    check("abort_data_c151", rec_d[151], 0);
    check("abort_data_c165", rec_d[165], 0);
    check("abort_busy_c182", rec_b[182], 1);
    check("abort_ready_c182", rec_r[182], 0);
    check("abort_ready_c183", rec_r[183], 1);
    check("abort_no_done", done_count(1, 200), 0);

    // Asynchronous reset mid-frame, then a clean frame.
    accept(8'h5A, 1'b0);
    capture(200);
    rst = 1'b0;
    #1;
    check("midrst_data", bus.data_o, 0);
    check("midrst_busy", bus.busy_o, 0);
    check("midrst_ready", bus.data_ready_o, 1);
    check("midrst_done", bus.frame_done_o, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_busy", bus.busy_o, 0);
    build(8'h3C);
    accept(8'h3C, 1'b0);
    capture(MaxCyc);
    check_frame("x3c");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
